// File: rtl/pinball_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pinball_pkg
// Description : Shared encodings and 100 MHz timing defaults for the paddle
//               input path.
// Revision    : 1.0 - initial release
// ============================================================================
package pinball_pkg;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_HOLD = 2'd1;
    localparam logic [1:0] c_ST_LOCK = 2'd2;

    localparam logic [1:0] c_DIR_NONE  = 2'd0;
    localparam logic [1:0] c_DIR_LEFT  = 2'd1;
    localparam logic [1:0] c_DIR_RIGHT = 2'd2;

    localparam int c_DEBOUNCE_CYCLES_DEF = 1_000_000;
    localparam int c_RAMP_CYCLES_DEF     = 25_000_000;
    localparam int c_LOCK_CYCLES_DEF     = 50_000_000;
    localparam int c_SPEED_MIN_DEF       = 3;
    localparam int c_SPEED_MAX_DEF       = 12;

    // Both pressed cancels out to NONE rather than favouring one side.
    function automatic logic [1:0] f_arbitrate(input logic left, input logic right);
        if (left && !right) return c_DIR_LEFT;
        if (right && !left) return c_DIR_RIGHT;
        return c_DIR_NONE;
    endfunction

endpackage
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// ============================================================================
// Module      : btn_debounce
// Description : Two-flop synchroniser plus counter-based debouncer for one
//               raw button input.
// Revision    : 1.0 - initial release
// ============================================================================
module btn_debounce
    import pinball_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = c_DEBOUNCE_CYCLES_DEF
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_btn_raw,
    output logic o_stable
);

    localparam int c_CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DEBOUNCE_CYCLES - 1);

    logic               r_sync1;
    logic               r_sync2;
    logic               r_stable;
    logic [c_CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sync1  <= 1'b0;
            r_sync2  <= 1'b0;
            r_stable <= 1'b0;
            r_cnt    <= '0;
        end else begin
            r_sync1 <= i_btn_raw;
            r_sync2 <= r_sync1;
            // Any sample agreeing with the accepted level restarts the count.
            if (r_sync2 == r_stable) begin
                r_cnt <= '0;
            end else if (r_cnt == c_CNT_LAST) begin
                r_stable <= r_sync2;
                r_cnt    <= '0;
            end else begin
                r_cnt <= r_cnt + c_CNT_W'(1);
            end
        end
    end

    assign o_stable = r_stable;

endmodule
`default_nettype wire

// File: rtl/paddle_input_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : paddle_input_ctrl
// Description : Debounced paddle buttons, direction arbitration, hold-to-
//               accelerate speed ramp and post-lose input lockout.
// Revision    : 1.0 - initial release
// ============================================================================
module paddle_input_ctrl
    import pinball_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = c_DEBOUNCE_CYCLES_DEF,
    parameter int RAMP_CYCLES     = c_RAMP_CYCLES_DEF,
    parameter int LOCK_CYCLES     = c_LOCK_CYCLES_DEF,
    parameter int SPEED_MIN       = c_SPEED_MIN_DEF,
    parameter int SPEED_MAX       = c_SPEED_MAX_DEF
) (
    input  logic       I_clk,
    input  logic       I_rst,
    input  logic       btn_left_raw,
    input  logic       btn_right_raw,
    input  logic       lose,
    output logic       to_left,
    output logic       to_right,
    output logic [3:0] bar_move_speed
);

    localparam int c_RAMP_W = (RAMP_CYCLES > 1) ? $clog2(RAMP_CYCLES) : 1;
    localparam int c_LOCK_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam logic [c_RAMP_W-1:0] c_RAMP_LAST = c_RAMP_W'(RAMP_CYCLES - 1);
    localparam logic [c_LOCK_W-1:0] c_LOCK_LAST = c_LOCK_W'(LOCK_CYCLES - 1);
    localparam logic [3:0] c_SPEED_MIN = 4'(SPEED_MIN);
    localparam logic [3:0] c_SPEED_MAX = 4'(SPEED_MAX);

    logic                w_left_stable;
    logic                w_right_stable;
    logic [1:0]          w_dir;
    logic [1:0]          r_state;
    logic [1:0]          r_hold_dir;
    logic [3:0]          r_speed;
    logic [c_RAMP_W-1:0] r_ramp_cnt;
    logic [c_LOCK_W-1:0] r_lock_cnt;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_left (
        .i_clk     (I_clk),
        .i_rst     (I_rst),
        .i_btn_raw (btn_left_raw),
        .o_stable  (w_left_stable)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_right (
        .i_clk     (I_clk),
        .i_rst     (I_rst),
        .i_btn_raw (btn_right_raw),
        .o_stable  (w_right_stable)
    );

    assign w_dir = f_arbitrate(w_left_stable, w_right_stable);

    always_ff @(posedge I_clk or posedge I_rst) begin
        if (I_rst) begin
            r_state        <= c_ST_IDLE;
            r_hold_dir     <= c_DIR_NONE;
            r_speed        <= c_SPEED_MIN;
            r_ramp_cnt     <= '0;
            r_lock_cnt     <= '0;
            to_left        <= 1'b0;
            to_right       <= 1'b0;
            bar_move_speed <= c_SPEED_MIN;
        end else if (lose) begin
            // Outputs bypass the state register here so the paddle stops on the very next edge.
            r_state        <= c_ST_LOCK;
            r_hold_dir     <= c_DIR_NONE;
            r_speed        <= c_SPEED_MIN;
            r_ramp_cnt     <= '0;
            r_lock_cnt     <= '0;
            to_left        <= 1'b0;
            to_right       <= 1'b0;
            bar_move_speed <= c_SPEED_MIN;
        end else begin
            to_left        <= (r_state == c_ST_HOLD) && (r_hold_dir == c_DIR_LEFT);
            to_right       <= (r_state == c_ST_HOLD) && (r_hold_dir == c_DIR_RIGHT);
            bar_move_speed <= (r_state == c_ST_HOLD) ? r_speed : c_SPEED_MIN;

            case (r_state)
                c_ST_IDLE: begin
                    r_speed <= c_SPEED_MIN;
                    if (w_dir != c_DIR_NONE) begin
                        r_state    <= c_ST_HOLD;
                        r_hold_dir <= w_dir;
                        r_ramp_cnt <= '0;
                    end
                end
                c_ST_HOLD: begin
                    if (w_dir == c_DIR_NONE) begin
                        r_state    <= c_ST_IDLE;
                        r_hold_dir <= c_DIR_NONE;
                        r_speed    <= c_SPEED_MIN;
                        r_ramp_cnt <= '0;
                    end else if (w_dir != r_hold_dir) begin
                        r_hold_dir <= w_dir;
                        r_speed    <= c_SPEED_MIN;
                        r_ramp_cnt <= '0;
                    end else if (r_ramp_cnt == c_RAMP_LAST) begin
                        r_ramp_cnt <= '0;
                        if (r_speed < c_SPEED_MAX) r_speed <= r_speed + 4'd1;
                    end else begin
                        r_ramp_cnt <= r_ramp_cnt + c_RAMP_W'(1);
                    end
                end
                c_ST_LOCK: begin
                    r_speed <= c_SPEED_MIN;
                    if (r_lock_cnt == c_LOCK_LAST) begin
                        r_state    <= c_ST_IDLE;
                        r_lock_cnt <= '0;
                    end else begin
                        r_lock_cnt <= r_lock_cnt + c_LOCK_W'(1);
                    end
                end
                default: begin
                    r_state    <= c_ST_IDLE;
                    r_hold_dir <= c_DIR_NONE;
                    r_speed    <= c_SPEED_MIN;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_paddle_input_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_paddle_input_ctrl
// Description : Self-checking bench for paddle_input_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_paddle_input_ctrl;

    localparam int DC   = 4;
    localparam int RAMP = 8;
    localparam int LOCK = 16;
    localparam int SMIN = 3;
    localparam int SMAX = 5;

    logic       I_clk = 1'b0;
    logic       I_rst;
    logic       btn_left_raw;
    logic       btn_right_raw;
    logic       lose;
    logic       to_left;
    logic       to_right;
    logic [3:0] bar_move_speed;

    int checks   = 0;
    int failures = 0;

    paddle_input_ctrl #(
        .DEBOUNCE_CYCLES (DC),
        .RAMP_CYCLES     (RAMP),
        .LOCK_CYCLES     (LOCK),
        .SPEED_MIN       (SMIN),
        .SPEED_MAX       (SMAX)
    ) dut (
        .I_clk          (I_clk),
        .I_rst          (I_rst),
        .btn_left_raw   (btn_left_raw),
        .btn_right_raw  (btn_right_raw),
        .lose           (lose),
        .to_left        (to_left),
        .to_right       (to_right),
        .bar_move_speed (bar_move_speed)
    );

    always #5 I_clk = ~I_clk;

    typedef struct {
        logic       l;
        logic       r;
        int         n;
        logic       el;
        logic       er;
        logic [3:0] es;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic el, input logic er, input logic [3:0] es);
        checks++;
        if (to_left !== el || to_right !== er || bar_move_speed !== es) begin
            failures++;
            $display("FAIL %s: got left=%0b right=%0b speed=%0d, want left=%0b right=%0b speed=%0d",
                     name, to_left, to_right, bar_move_speed, el, er, es);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge I_clk);
            #1;
        end
    endtask

    task automatic do_reset();
        btn_left_raw  = 1'b0;
        btn_right_raw = 1'b0;
        lose          = 1'b0;
        I_rst         = 1'b1;
        step(2);
        I_rst = 1'b0;
    endtask

    // Reference model: debounced levels tracked by run length of disagreeing
    // samples, paddle speed derived from time spent holding one direction.
    typedef enum {M_IDLE, M_HOLD, M_LOCK} mmode_t;
    mmode_t     m_mode;
    int         m_hdir;      // 1 left, 2 right
    int         m_age;       // edges since this direction started being held
    int         m_lock_age;
    logic [1:0] m_hist_l, m_hist_r;  // [0] raw one edge ago, [1] two edges ago
    logic       m_stb_l, m_stb_r;
    int         m_run_l, m_run_r;
    logic       m_el, m_er;
    int         m_es;

    task automatic model_reset();
        m_mode = M_IDLE; m_hdir = 0; m_age = 0; m_lock_age = 0;
        m_hist_l = '0; m_hist_r = '0; m_stb_l = 1'b0; m_stb_r = 1'b0;
        m_run_l = 0; m_run_r = 0;
    endtask

    task automatic model_edge(input logic l, input logic r, input logic ls);
        int d;
        int s;
        d = (m_stb_l && !m_stb_r) ? 1 : (m_stb_r && !m_stb_l) ? 2 : 0;
        s = SMIN + m_age / RAMP;
        if (s > SMAX) s = SMAX;
        if (ls) begin
            m_el = 1'b0; m_er = 1'b0; m_es = SMIN;
            m_mode = M_LOCK; m_lock_age = 0;
        end else begin
            m_el = (m_mode == M_HOLD) && (m_hdir == 1);
            m_er = (m_mode == M_HOLD) && (m_hdir == 2);
            m_es = (m_mode == M_HOLD) ? s : SMIN;
            case (m_mode)
                M_IDLE: if (d != 0) begin m_mode = M_HOLD; m_hdir = d; m_age = 0; end
                M_HOLD: begin
                    if (d == 0) m_mode = M_IDLE;
                    else if (d != m_hdir) begin m_hdir = d; m_age = 0; end
                    else m_age++;
                end
                default: begin
                    if (m_lock_age == LOCK - 1) m_mode = M_IDLE;
                    else m_lock_age++;
                end
            endcase
        end
        if (m_hist_l[1] == m_stb_l) m_run_l = 0;
        else begin
            m_run_l++;
            if (m_run_l == DC) begin m_stb_l = m_hist_l[1]; m_run_l = 0; end
        end
        if (m_hist_r[1] == m_stb_r) m_run_r = 0;
        else begin
            m_run_r++;
            if (m_run_r == DC) begin m_stb_r = m_hist_r[1]; m_run_r = 0; end
        end
        m_hist_l = {m_hist_l[0], l};
        m_hist_r = {m_hist_r[0], r};
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  dur_l, dur_r;
        logic rl, rr, rs;

        // Press timeline from idle: outputs at edge 8, speed 4 at 16, 5 at 24.
        vecs[0]  = '{1'b1, 1'b0,  7, 1'b0, 1'b0, 4'd3};
        vecs[1]  = '{1'b1, 1'b0,  1, 1'b1, 1'b0, 4'd3};
        vecs[2]  = '{1'b1, 1'b0,  7, 1'b1, 1'b0, 4'd3};
        vecs[3]  = '{1'b1, 1'b0,  1, 1'b1, 1'b0, 4'd4};
        vecs[4]  = '{1'b1, 1'b0,  8, 1'b1, 1'b0, 4'd5};
        vecs[5]  = '{1'b1, 1'b0, 16, 1'b1, 1'b0, 4'd5};
        vecs[6]  = '{1'b0, 1'b1,  7, 1'b1, 1'b0, 4'd5};
        vecs[7]  = '{1'b0, 1'b1,  1, 1'b0, 1'b1, 4'd3};
        vecs[8]  = '{1'b1, 1'b1,  7, 1'b0, 1'b1, 4'd3};
        vecs[9]  = '{1'b1, 1'b1,  1, 1'b0, 1'b0, 4'd3};
        vecs[10] = '{1'b1, 1'b1, 10, 1'b0, 1'b0, 4'd3};
        vecs[11] = '{1'b0, 1'b0, 12, 1'b0, 1'b0, 4'd3};

        btn_left_raw = 1'b0; btn_right_raw = 1'b0; lose = 1'b0; I_rst = 1'b1;
        step(3);
        check("reset_state", 1'b0, 1'b0, 4'd3);
        I_rst = 1'b0;

        for (int i = 0; i < 12; i++) begin
            btn_left_raw  = vecs[i].l;
            btn_right_raw = vecs[i].r;
            step(vecs[i].n);
            check($sformatf("vec%0d", i), vecs[i].el, vecs[i].er, vecs[i].es);
        end

        // Glitch of three sampled cycles must be rejected.
        do_reset();
        btn_left_raw = 1'b1;
        step(3);
        btn_left_raw = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            check("glitch", 1'b0, 1'b0, 4'd3);
        end

        // Asynchronous reset mid-hold at speed 4.
        do_reset();
        btn_right_raw = 1'b1;
        step(16);
        check("pre_reset_hold", 1'b0, 1'b1, 4'd4);
        #2 I_rst = 1'b1;
        #1 check("async_reset", 1'b0, 1'b0, 4'd3);
        @(posedge I_clk);
        #1 I_rst = 1'b0;
        step(7);
        check("post_reset_idle", 1'b0, 1'b0, 4'd3);
        step(1);
        check("post_reset_press", 1'b0, 1'b1, 4'd3);
        step(7);
        check("post_reset_no_ramp", 1'b0, 1'b1, 4'd3);
        step(1);
        check("post_reset_ramp", 1'b0, 1'b1, 4'd4);

        // Lose while holding left at speed 4.
        do_reset();
        btn_left_raw = 1'b1;
        step(16);
        check("pre_lose", 1'b1, 1'b0, 4'd4);
        lose = 1'b1;
        step(1);
        lose = 1'b0;
        check("lose_drop", 1'b0, 1'b0, 4'd3);
        step(16);
        check("lock_exit_idle", 1'b0, 1'b0, 4'd3);
        step(1);
        check("lock_idle_to_hold", 1'b0, 1'b0, 4'd3);
        step(1);
        check("lock_resume", 1'b1, 1'b0, 4'd3);

        // Second lose ten cycles into the lockout restarts it.
        do_reset();
        btn_left_raw = 1'b1;
        step(16);
        lose = 1'b1;
        step(1);
        lose = 1'b0;
        step(9);
        lose = 1'b1;
        step(1);
        lose = 1'b0;
        check("retrig_drop", 1'b0, 1'b0, 4'd3);
        step(8);
        check("retrig_extended", 1'b0, 1'b0, 4'd3);
        step(9);
        check("retrig_idle_to_hold", 1'b0, 1'b0, 4'd3);
        step(1);
        check("retrig_resume", 1'b1, 1'b0, 4'd3);

        // Randomised run against the reference model.
        do_reset();
        model_reset();
        dur_l = 0; dur_r = 0; rl = 1'b0; rr = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (dur_l == 0) begin rl = 1'($urandom_range(0, 1)); dur_l = $urandom_range(1, 40); end
            if (dur_r == 0) begin rr = 1'($urandom_range(0, 1)); dur_r = $urandom_range(1, 40); end
            dur_l--; dur_r--;
            rs = ($urandom_range(0, 79) == 0);
            btn_left_raw  = rl;
            btn_right_raw = rr;
            lose          = rs;
            step(1);
            model_edge(rl, rr, rs);
            check($sformatf("random_cycle%0d", i), m_el, m_er, 4'(m_es));
        end
        lose = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/paddle_input_ctrl.md
# paddle_input_ctrl

Conditions the two raw paddle buttons and generates the paddle-motion controls consumed by the VGA display stage (`to_left`, `to_right`, `bar_move_speed`). It synchronises and debounces each button and arbitrates direction. A hold-to-accelerate FSM ramps paddle speed while a direction is held. A `lose` pulse from the display stage forces a short input lockout. The block sits between the board pins and `VGA_Dispay` in the top level and replaces the constant speed register.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 1_000_000: stable cycles required before a button change is accepted (10 ms at 100 MHz).
- `RAMP_CYCLES`, default 25_000_000: hold cycles per speed increment (250 ms).
- `LOCK_CYCLES`, default 50_000_000: input lockout after `lose` (500 ms).
- `SPEED_MIN`, default 3: initial and idle speed, 4-bit.
- `SPEED_MAX`, default 12: saturation speed, 4-bit, ≥ `SPEED_MIN`.

Ports:
- `I_clk` in 1: system clock, 100 MHz.
- `I_rst` in 1: reset, asynchronous, active-high. This is the single clock domain.
- `btn_left_raw` in 1: raw left button, asynchronous, high = pressed.
- `btn_right_raw` in 1: raw right button, asynchronous, high = pressed.
- `lose` in 1: single-cycle pulse from the display stage, synchronous to `I_clk`.
- `to_left` out 1: move paddle left, registered.
- `to_right` out 1: move paddle right, registered.
- `bar_move_speed` out 4: paddle speed, registered.

## Operation
- **Sync:** each raw button passes through a 2-flop synchroniser. Reset value is 0.
- **Debounce**, per button:
  - Hold a `stable` bit and a counter of width clog2(`DEBOUNCE_CYCLES`).
  - When synced == `stable`, the counter clears.
  - Otherwise the counter increments. On the cycle it equals `DEBOUNCE_CYCLES-1`, `stable` takes the synced value and the counter clears.
- **Arbitration:** `dir` is LEFT if only left is stable-high, RIGHT if only right is, and NONE if neither or both are.
- **FSM**, states IDLE, HOLD, LOCK:
  - IDLE: outputs are 0 and speed = `SPEED_MIN`. If `dir` ≠ NONE, go to HOLD with the ramp timer cleared.
  - HOLD:
    - `to_left`/`to_right` follow `dir`.
    - The ramp timer increments. When it reaches `RAMP_CYCLES-1`, speed increments saturating at `SPEED_MAX` and the timer clears.
    - If `dir` becomes NONE, go to IDLE and set speed to `SPEED_MIN`.
    - A direct LEFT↔RIGHT change stays in HOLD: speed resets to `SPEED_MIN`, the timer clears, and the outputs switch the same cycle.
  - LOCK: outputs are 0, speed = `SPEED_MIN`, and the lock timer counts. At `LOCK_CYCLES-1`, go to IDLE.
  - `lose`=1 in any state goes to LOCK with the lock timer cleared. This has priority over every other transition. A `lose` pulse during LOCK restarts the timer.
- **Debounce during LOCK:** the debouncers keep running through LOCK. If a button is still held on LOCK exit, IDLE→HOLD occurs on the next cycle.
- **Reset values:**
  - FSM IDLE.
  - `to_left`=0, `to_right`=0, `bar_move_speed`=`SPEED_MIN`.
  - All counters 0.
  - Synchronisers and `stable` 0.
- **Reset mid-operation:** reset takes effect immediately and asynchronously, with no partial ramp retained.

## Timing
- **Press latency:** a raw edge held steady asserts `to_left`/`to_right` exactly `DEBOUNCE_CYCLES`+4 `I_clk` edges after the first sampling edge. This breaks down as 2 sync, `DEBOUNCE_CYCLES` count, 1 FSM transition and 1 output register.
- **Release latency:** identical.
- **Glitch rejection:** a glitch shorter than `DEBOUNCE_CYCLES` cycles after sync produces no output change.
- **Speed ramp:** the first increment occurs `RAMP_CYCLES` cycles after entering HOLD. Subsequent increments follow every `RAMP_CYCLES` cycles until `SPEED_MAX`.
- **`lose` response:** outputs drop to 0 on the first edge after the `lose` pulse, which is 1-cycle latency.
- **Outputs:** all are registered and glitch-free, suitable for the display stage's frame-rate sampling.

## Structure
- **Shared package `pinball_pkg`:**
  - FSM state encoding (2-bit, IDLE=0, HOLD=1, LOCK=2).
  - `dir` encoding (NONE=0, LEFT=1, RIGHT=2).
  - Default timing constants at 100 MHz.
- **Sub-module `btn_debounce`:** parameter `DEBOUNCE_CYCLES`, containing the synchroniser, counter and `stable` register. It is instantiated twice.
- **Top-level body:** arbitration, FSM, ramp/lock timers and output registers.

## Test plan
All scenarios use `DEBOUNCE_CYCLES`=4, `RAMP_CYCLES`=8, `LOCK_CYCLES`=16, `SPEED_MIN`=3, `SPEED_MAX`=5.
- **Reset:** assert `I_rst` mid-HOLD at speed 4. Outputs go to 0/0/3 immediately, and the FSM is IDLE after release.
- **Debounce:** left high for 3 cycles then low gives `to_left` never asserted. Left held steady gives `to_left`=1 exactly 8 edges after the first sample.
- **Ramp:** hold right for 40 cycles. Speed goes 3→4 after 8 cycles in HOLD, 4→5 after 16, and stays 5, saturated.
- **Direction swap and both pressed:**
  - Left held at speed 5, then switch to right. Within one cycle of the debounced change, `to_left`=0, `to_right`=1 and speed=3.
  - Both held gives both outputs 0.
- **Lose:** a `lose` pulse while holding left at speed 4 gives outputs 0/0/3 the next edge. The FSM holds LOCK for 16 cycles, then returns to HOLD (`to_left`=1) one cycle after IDLE.
- **Lose retrigger:** a second `lose` 10 cycles into LOCK extends the lockout to 16 cycles from the second pulse.
